burst_sequencer: RTL and testbench
==================================

BURST_SEQUENCER -- requirements
Module: burst_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, width of the burst-length count and of the remaining counter.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: go  input  1  request to start a burst; sampled every cycle.
REQ-005 Port: count  input  WIDTH  number of timer intervals in the burst; sampled only when go is accepted.
REQ-006 Port: abort  input  1  cancels an active burst.
REQ-007 Port: tmr_done  input  1  done from the downstream interval timer; one-cycle pulse, combinational in the timer.
REQ-008 Port: tmr_start  output  1  start to the downstream interval timer.
REQ-009 Port: busy  output  1  high while state is RUN or DRAIN.
REQ-010 Port: tick  output  1  one-cycle pulse per completed interval.
REQ-011 Port: finished  output  1  one-cycle pulse when the last interval of a burst completes.
REQ-012 Port: remaining  output  WIDTH  intervals still outstanding, registered.

Function
REQ-013 States SHALL be IDLE, RUN and DRAIN.
REQ-014 IDLE with go=1 and count!=0: tmr_start=1 in the same cycle (combinational), remaining<=count, next state RUN.
REQ-015 IDLE with go=1 and count==0: no tmr_start, finished=1 in the same cycle, tick=0, state stays IDLE.
REQ-016 IDLE SHALL ignore tmr_done and abort.
REQ-017 RUN with tmr_done=1 and abort=0: tick=1 and remaining<=remaining-1.
REQ-018 In that RUN cycle, if remaining>1, tmr_start=1 in the same cycle so the timer restarts back-to-back, and state stays RUN.
REQ-019 In that RUN cycle, if remaining==1, finished=1, tmr_start=0, and next state IDLE.
REQ-020 RUN with tmr_done=0: tmr_start=0, no change to remaining.
REQ-021 RUN with abort=1 and tmr_done=0: next state DRAIN, remaining<=0, no tick, no finished.
REQ-022 RUN with abort=1 and tmr_done=1: tick=0, finished=0, tmr_start=0, remaining<=0, next state IDLE (the timer is already stopping).
REQ-023 DRAIN holds tmr_start=0 and waits for tmr_done; on tmr_done, next state IDLE with no tick or finished pulse, so a later go is never lost to a still-running timer.
REQ-024 go SHALL be ignored in RUN and DRAIN; count is not re-sampled.
REQ-025 tick, finished and tmr_start SHALL be combinational and never asserted outside the cases above.
REQ-026 remaining SHALL never wrap below 0; decrement applies only in REQ-017.
REQ-027 tmr_start SHALL be asserted at most once per tmr_done event plus once per accepted go.

Reset
REQ-028 rst_n=0 at a clock edge: state<=IDLE, remaining<=0; while in reset, busy, tick, finished and tmr_start SHALL be 0 regardless of inputs.
REQ-029 Reset mid-burst SHALL abandon the burst with no finished pulse.
REQ-030 The downstream timer SHALL share rst_n so that both blocks leave reset idle together.

Verification (bench timer with STOP_COUNT=4; go is a one-cycle pulse in cycle 0; all timing is relative to cycle 0)
REQ-031 go, count=3 -> tmr_start in cycles 0, 5 and 9; tick in cycles 5, 9 and 13; finished only in cycle 13; remaining 3,2,1,0; busy high cycles 1-13.
REQ-032 go, count=0 -> finished in cycle 0; no tmr_start, no tick; busy stays 0.
REQ-033 go, count=2; abort in cycle 3 -> DRAIN; timer done in cycle 5 produces no tick and no finished; IDLE from cycle 6; a go in cycle 6 yields tmr_start in cycle 6 and tick in cycle 11.
REQ-034 go, count=2; abort coincident with tmr_done in cycle 5 -> tick=0, finished=0, tmr_start=0, IDLE in cycle 6, remaining=0.
REQ-035 go, count=5; rst_n=0 in cycle 7 -> from cycle 8 busy=0, remaining=0; no finished pulse ever appears.
REQ-036 go repeated each cycle during a count=2 burst -> ignored; exactly 2 ticks and 1 finished.

Source files
------------

// File: rtl/burst_sequencer_if.sv
// Handshake bundle between the burst sequencer, its requester and the downstream interval timer.
// The slave modport is the sequencer's view; master is the requester/timer side.
interface burst_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             go;
  logic [WIDTH-1:0] count;
  logic             abort;
  logic             tmr_done;
  logic             tmr_start;
  logic             busy;
  logic             tick;
  logic             finished;
  logic [WIDTH-1:0] remaining;

  modport master (
    output go, count, abort, tmr_done,
    input  tmr_start, busy, tick, finished, remaining
  );

  modport slave (
    input  go, count, abort, tmr_done,
    output tmr_start, busy, tick, finished, remaining
  );
endinterface

// File: rtl/burst_sequencer.sv
// Runs a burst of back-to-back timer intervals, pulsing tick per interval and finished on the last.
// state | meaning: IDLE = waiting for go; RUN = timer interval in flight; DRAIN = aborted, waiting for timer to stop
module burst_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  burst_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             busy_q, busy_d;
  logic             tmr_start_d, tick_d, finished_d;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tmr_start_d = 1'b0;
    tick_d      = 1'b0;
    finished_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          if (bus.count != '0) begin
            tmr_start_d = 1'b1;
            remaining_d = bus.count;
            state_d     = RUN;
          end else begin
            finished_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          // abort coincident with done: the timer is already stopping, no drain needed
          remaining_d = '0;
          state_d     = bus.tmr_done ? IDLE : DRAIN;
        end else if (bus.tmr_done) begin
          tick_d = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - WIDTH'(1);
          end
          if (remaining_q > WIDTH'(1)) begin
            tmr_start_d = 1'b1;
          end else begin
            finished_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.tmr_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
    end
  end

  // Strobes and busy are forced low for the whole reset cycle, not just after the edge.
  assign bus.tmr_start = rst_n & tmr_start_d;
  assign bus.tick      = rst_n & tick_d;
  assign bus.finished  = rst_n & finished_d;
  assign bus.busy      = rst_n & busy_q;
  assign bus.remaining = remaining_q;

endmodule

// File: tb/tb_burst_sequencer.sv
// Self-checking bench for burst_sequencer with a behavioural interval timer (STOP_COUNT=4).
// Directed timing scenarios plus a randomized run against a rule-level reference model.
module tb_burst_sequencer;
  localparam int WIDTH      = 8;
  localparam int STOP_COUNT = 4;
  localparam int NREC       = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  burst_sequencer_if #(.WIDTH(WIDTH)) bif ();

  burst_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Interval timer: a start from idle gives done STOP_COUNT+1 cycles later; a restart in the
  // done cycle counts that cycle as the first of the new interval, giving STOP_COUNT cycles.
  logic tm_run = 1'b0;
  int   tm_cnt = 0;
  assign bif.tmr_done = tm_run && (tm_cnt == 0);
  always @(posedge clk) begin
    if (!rst_n) begin
      tm_run <= 1'b0;
      tm_cnt <= 0;
    end else if (bif.tmr_start) begin
      tm_run <= 1'b1;
      tm_cnt <= bif.tmr_done ? STOP_COUNT - 1 : STOP_COUNT;
    end else if (bif.tmr_done) begin
      tm_run <= 1'b0;
    end else if (tm_run) begin
      tm_cnt <= tm_cnt - 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc;

  logic             o_start, o_tick, o_fin, o_busy, o_done;
  logic [WIDTH-1:0] o_rem;
  logic             a_start [NREC];
  logic             a_tick  [NREC];
  logic             a_fin   [NREC];
  logic             a_busy  [NREC];
  logic             a_done  [NREC];
  logic [WIDTH-1:0] a_rem   [NREC];

  // One clock cycle: drive inputs just after the edge, sample outputs before the next one.
  task automatic run_cycle(input logic g, input logic [WIDTH-1:0] c, input logic a, input logic r);
    @(posedge clk);
    #1;
    bif.go    = g;
    bif.count = c;
    bif.abort = a;
    rst_n     = r;
    #1;
    o_start = bif.tmr_start;
    o_tick  = bif.tick;
    o_fin   = bif.finished;
    o_busy  = bif.busy;
    o_rem   = bif.remaining;
    o_done  = bif.tmr_done;
    if (cyc < NREC) begin
      a_start[cyc] = o_start;
      a_tick[cyc]  = o_tick;
      a_fin[cyc]   = o_fin;
      a_busy[cyc]  = o_busy;
      a_rem[cyc]   = o_rem;
      a_done[cyc]  = o_done;
    end
    cyc++;
  endtask

  task automatic test_reset;
    cyc = 0;
    for (int i = 0; i < 4; i++) run_cycle(1'b1, WIDTH'($urandom_range(1, 255)), 1'($urandom), 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({a_start[c], a_tick[c], a_fin[c], a_busy[c]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset strobes c%0d: got start/tick/fin/busy=%b%b%b%b want 0000", c, a_start[c], a_tick[c], a_fin[c], a_busy[c]);
      end
      checks++;
      if (a_rem[c] !== '0) begin
        errors++;
        $display("FAIL reset remaining c%0d: got %0d want 0", c, a_rem[c]);
      end
    end
    run_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (o_busy !== 1'b0 || o_rem !== '0) begin
      errors++;
      $display("FAIL reset release: got busy=%b rem=%0d want busy=0 rem=0", o_busy, o_rem);
    end
  endtask

  task automatic test_burst;
    logic [NREC-1:0] m_start, m_tick, m_fin, m_busy;
    int e_rem;
    m_start = '0; m_tick = '0; m_fin = '0; m_busy = '0;
    m_start[0] = 1'b1; m_start[5] = 1'b1; m_start[9] = 1'b1;
    m_tick[5] = 1'b1; m_tick[9] = 1'b1; m_tick[13] = 1'b1;
    m_fin[13] = 1'b1;
    for (int c = 1; c <= 13; c++) m_busy[c] = 1'b1;
    cyc = 0;
    run_cycle(1'b1, WIDTH'(3), 1'b0, 1'b1);
    for (int i = 1; i < 17; i++) run_cycle(1'b0, WIDTH'($urandom), 1'b0, 1'b1);
    e_rem = 0;
    for (int c = 0; c < 17; c++) begin
      checks += 5;
      if (a_start[c] !== m_start[c]) begin errors++; $display("FAIL burst tmr_start c%0d: got %b want %b", c, a_start[c], m_start[c]); end
      if (a_tick[c] !== m_tick[c]) begin errors++; $display("FAIL burst tick c%0d: got %b want %b", c, a_tick[c], m_tick[c]); end
      if (a_fin[c] !== m_fin[c]) begin errors++; $display("FAIL burst finished c%0d: got %b want %b", c, a_fin[c], m_fin[c]); end
      if (a_busy[c] !== m_busy[c]) begin errors++; $display("FAIL burst busy c%0d: got %b want %b", c, a_busy[c], m_busy[c]); end
      if (a_rem[c] !== WIDTH'(e_rem)) begin errors++; $display("FAIL burst remaining c%0d: got %0d want %0d", c, a_rem[c], e_rem); end
      if (c == 0) e_rem = 3;
      else if (m_tick[c]) e_rem--;
    end
  endtask

  task automatic test_zero_count;
    cyc = 0;
    run_cycle(1'b1, '0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) run_cycle(1'b0, WIDTH'($urandom), 1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      checks += 3;
      if (a_fin[c] !== (c == 0)) begin errors++; $display("FAIL zero finished c%0d: got %b want %b", c, a_fin[c], (c == 0)); end
      if ({a_start[c], a_tick[c], a_busy[c]} !== 3'b000) begin
        errors++;
        $display("FAIL zero start/tick/busy c%0d: got %b%b%b want 000", c, a_start[c], a_tick[c], a_busy[c]);
      end
      if (a_rem[c] !== '0) begin errors++; $display("FAIL zero remaining c%0d: got %0d want 0", c, a_rem[c]); end
    end
  endtask

  task automatic test_abort_drain;
    logic [NREC-1:0] m_start, m_tick, m_busy;
    int e_rem;
    m_start = '0; m_tick = '0; m_busy = '0;
    m_start[0] = 1'b1; m_start[6] = 1'b1;
    m_tick[11] = 1'b1;
    for (int c = 1; c <= 5; c++) m_busy[c] = 1'b1;
    for (int c = 7; c <= 11; c++) m_busy[c] = 1'b1;
    cyc = 0;
    for (int i = 0; i < 15; i++)
      run_cycle(i == 0 || i == 6, (i == 0) ? WIDTH'(2) : (i == 6) ? WIDTH'(1) : WIDTH'($urandom), i == 3, 1'b1);
    checks++;
    if (a_done[5] !== 1'b1) begin errors++; $display("FAIL drain timer done c5: got %b want 1", a_done[5]); end
    e_rem = 0;
    for (int c = 0; c < 15; c++) begin
      checks += 5;
      if (a_start[c] !== m_start[c]) begin errors++; $display("FAIL drain tmr_start c%0d: got %b want %b", c, a_start[c], m_start[c]); end
      if (a_tick[c] !== m_tick[c]) begin errors++; $display("FAIL drain tick c%0d: got %b want %b", c, a_tick[c], m_tick[c]); end
      if (a_fin[c] !== m_tick[c]) begin errors++; $display("FAIL drain finished c%0d: got %b want %b", c, a_fin[c], m_tick[c]); end
      if (a_busy[c] !== m_busy[c]) begin errors++; $display("FAIL drain busy c%0d: got %b want %b", c, a_busy[c], m_busy[c]); end
      if (a_rem[c] !== WIDTH'(e_rem)) begin errors++; $display("FAIL drain remaining c%0d: got %0d want %0d", c, a_rem[c], e_rem); end
      if (c == 0) e_rem = 2;
      else if (c == 3) e_rem = 0;
      else if (c == 6) e_rem = 1;
      else if (m_tick[c]) e_rem--;
    end
  endtask

  task automatic test_abort_done;
    int e_rem;
    cyc = 0;
    for (int i = 0; i < 12; i++) run_cycle(i == 0, (i == 0) ? WIDTH'(2) : WIDTH'($urandom), i == 5, 1'b1);
    checks++;
    if (a_done[5] !== 1'b1) begin errors++; $display("FAIL abortdone timer done c5: got %b want 1", a_done[5]); end
    e_rem = 0;
    for (int c = 0; c < 12; c++) begin
      checks += 5;
      if (a_start[c] !== (c == 0)) begin errors++; $display("FAIL abortdone tmr_start c%0d: got %b want %b", c, a_start[c], (c == 0)); end
      if (a_tick[c] !== 1'b0) begin errors++; $display("FAIL abortdone tick c%0d: got %b want 0", c, a_tick[c]); end
      if (a_fin[c] !== 1'b0) begin errors++; $display("FAIL abortdone finished c%0d: got %b want 0", c, a_fin[c]); end
      if (a_busy[c] !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL abortdone busy c%0d: got %b want %b", c, a_busy[c], (c >= 1 && c <= 5)); end
      if (a_rem[c] !== WIDTH'(e_rem)) begin errors++; $display("FAIL abortdone remaining c%0d: got %0d want %0d", c, a_rem[c], e_rem); end
      if (c == 0) e_rem = 2;
      else if (c == 5) e_rem = 0;
    end
  endtask

  task automatic test_reset_mid_burst;
    int e_rem;
    cyc = 0;
    for (int i = 0; i < 30; i++) run_cycle(i == 0, (i == 0) ? WIDTH'(5) : WIDTH'($urandom), 1'b0, i != 7);
    e_rem = 0;
    for (int c = 0; c < 30; c++) begin
      checks += 5;
      if (a_start[c] !== (c == 0 || c == 5)) begin errors++; $display("FAIL rstmid tmr_start c%0d: got %b want %b", c, a_start[c], (c == 0 || c == 5)); end
      if (a_tick[c] !== (c == 5)) begin errors++; $display("FAIL rstmid tick c%0d: got %b want %b", c, a_tick[c], (c == 5)); end
      if (a_fin[c] !== 1'b0) begin errors++; $display("FAIL rstmid finished c%0d: got %b want 0", c, a_fin[c]); end
      if (a_busy[c] !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL rstmid busy c%0d: got %b want %b", c, a_busy[c], (c >= 1 && c <= 6)); end
      if (a_rem[c] !== WIDTH'(e_rem)) begin errors++; $display("FAIL rstmid remaining c%0d: got %0d want %0d", c, a_rem[c], e_rem); end
      if (c == 0) e_rem = 5;
      else if (c == 5) e_rem = 4;
      else if (c == 7) e_rem = 0;
    end
  endtask

  task automatic test_go_ignored;
    int e_rem, n_tick, n_fin;
    cyc = 0;
    for (int i = 0; i < 16; i++)
      run_cycle(i <= 9, (i == 0) ? WIDTH'(2) : WIDTH'($urandom_range(3, 255)), 1'b0, 1'b1);
    e_rem = 0; n_tick = 0; n_fin = 0;
    for (int c = 0; c < 16; c++) begin
      checks += 3;
      if (a_start[c] !== (c == 0 || c == 5)) begin errors++; $display("FAIL goign tmr_start c%0d: got %b want %b", c, a_start[c], (c == 0 || c == 5)); end
      if (a_busy[c] !== (c >= 1 && c <= 9)) begin errors++; $display("FAIL goign busy c%0d: got %b want %b", c, a_busy[c], (c >= 1 && c <= 9)); end
      if (a_rem[c] !== WIDTH'(e_rem)) begin errors++; $display("FAIL goign remaining c%0d: got %0d want %0d", c, a_rem[c], e_rem); end
      if (a_tick[c] === 1'b1) n_tick++;
      if (a_fin[c] === 1'b1) n_fin++;
      if (c == 0) e_rem = 2;
      else if (c == 5 || c == 9) e_rem--;
    end
    checks += 3;
    if (n_tick != 2) begin errors++; $display("FAIL goign tick count: got %0d want 2", n_tick); end
    if (n_fin != 1) begin errors++; $display("FAIL goign finished count: got %0d want 1", n_fin); end
    if (a_fin[9] !== 1'b1) begin errors++; $display("FAIL goign finished c9: got %b want 1", a_fin[9]); end
  endtask

  // Reference: a burst owes `left` intervals; an aborted burst waits out the timer before go is accepted again.
  task automatic test_random;
    bit   in_burst, waiting, g, a, r;
    int   left;
    logic [WIDTH-1:0] c;
    bit   e_start, e_tick, e_fin, e_busy;
    int   e_rem;
    cyc = NREC;
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    in_burst = 0; waiting = 0; left = 0;
    for (int i = 0; i < 1500; i++) begin
      g = ($urandom_range(0, 2) == 0);
      c = WIDTH'($urandom_range(0, 3));
      a = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 199) != 0);
      run_cycle(g, c, a, r);
      e_start = 0; e_tick = 0; e_fin = 0;
      e_busy = r && (in_burst || waiting);
      e_rem = left;
      if (!r) begin
        in_burst = 0; waiting = 0; left = 0;
      end else if (in_burst) begin
        if (a) begin
          left = 0; in_burst = 0; waiting = !o_done;
        end else if (o_done) begin
          e_tick = 1;
          left = left - 1;
          if (left > 0) e_start = 1;
          else begin e_fin = 1; in_burst = 0; end
        end
      end else if (waiting) begin
        if (o_done) waiting = 0;
      end else if (g) begin
        if (c != 0) begin e_start = 1; left = int'(c); in_burst = 1; end
        else e_fin = 1;
      end
      checks += 5;
      if (o_start !== e_start) begin errors++; $display("FAIL random tmr_start step %0d: got %b want %b", i, o_start, e_start); end
      if (o_tick !== e_tick) begin errors++; $display("FAIL random tick step %0d: got %b want %b", i, o_tick, e_tick); end
      if (o_fin !== e_fin) begin errors++; $display("FAIL random finished step %0d: got %b want %b", i, o_fin, e_fin); end
      if (o_busy !== e_busy) begin errors++; $display("FAIL random busy step %0d: got %b want %b", i, o_busy, e_busy); end
      if (o_rem !== WIDTH'(e_rem)) begin errors++; $display("FAIL random remaining step %0d: got %0d want %0d", i, o_rem, e_rem); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bif.go    = 1'b0;
    bif.count = '0;
    bif.abort = 1'b0;
    test_reset();
    test_burst();
    test_zero_count();
    test_abort_drain();
    test_abort_done();
    test_reset_mid_burst();
    test_go_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
